// File: rtl/uart_pkg.sv
// Shared constants for the board UART: FSM state codes, the transmit message ROM
// and a lookup helper used by the transmitter.
package uart_pkg;

  localparam int MSG_LEN = 12;

  // "Hello UART\r\n"
  localparam logic [7:0] MSG_ROM [MSG_LEN] = '{
    8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
    8'h55, 8'h41, 8'h52, 8'h54, 8'h0D, 8'h0A
  };

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_WAIT  = 3'd2;
  localparam logic [2:0] RX_READ  = 3'd3;
  localparam logic [2:0] RX_STOP  = 3'd4;

  localparam logic [2:0] TX_IDLE     = 3'd0;
  localparam logic [2:0] TX_START    = 3'd1;
  localparam logic [2:0] TX_WRITE    = 3'd2;
  localparam logic [2:0] TX_STOP     = 3'd3;
  localparam logic [2:0] TX_DEBOUNCE = 3'd4;

  function automatic logic [7:0] msg_byte(input logic [3:0] idx);
    return MSG_ROM[idx];
  endfunction

endpackage

// File: rtl/uart_if.sv
// Board-pin bundle for the UART: serial lines, LED bank and user button.
interface uart_if;
  logic       uart_rx;
  logic       uart_tx;
  logic       btn;
  logic [5:0] led;

  modport master (output uart_rx, output btn, input uart_tx, input led);
  modport slave  (input uart_rx, input btn, output uart_tx, output led);
endinterface

// File: rtl/uart_tx_msg.sv
// Button-triggered transmitter: sends the fixed message once per press as
// back-to-back 8N1 frames, then waits for a stable release.
module uart_tx_msg
  import uart_pkg::*;
#(
  parameter int DELAY_FRAMES = 234
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic tx
);

  localparam int CW = $clog2(DELAY_FRAMES * 2) + 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(DELAY_FRAMES - 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(2 * DELAY_FRAMES - 1);

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [3:0]    byte_idx;
  logic [7:0]    data;

  // tx is registered and updated on the cycle each bit period begins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= TX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      data     <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        TX_IDLE: begin
          if (!btn) begin
            data     <= msg_byte(4'd0);
            byte_idx <= '0;
            cnt      <= '0;
            tx       <= 1'b0;
            state    <= TX_START;
          end
        end
        TX_START: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= data[0];
            state   <= TX_WRITE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TX_WRITE: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= TX_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= data[bit_idx + 3'd1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (byte_idx == 4'(MSG_LEN - 1)) begin
              state <= TX_DEBOUNCE;
            end else begin
              byte_idx <= byte_idx + 4'd1;
              data     <= msg_byte(byte_idx + 4'd1);
              tx       <= 1'b0;
              state    <= TX_START;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TX_DEBOUNCE: begin
          // any low sample restarts the release window
          if (!btn) begin
            cnt <= '0;
          end else if (cnt == DEB_LAST) begin
            cnt   <= '0;
            state <= TX_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart.sv
// Board-level 8N1 UART: received bytes drive the active-low LEDs, a button
// press sends a greeting. RX runs here, TX lives in uart_tx_msg.
module uart
  import uart_pkg::*;
#(
  parameter int DELAY_FRAMES = 234
) (
  input logic clk,
  input logic rst,
  uart_if.slave pins
);

  localparam int CW = $clog2(DELAY_FRAMES * 2) + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(DELAY_FRAMES / 2 - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(DELAY_FRAMES - 2);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DELAY_FRAMES - 1);

  logic          rx_meta, rx, btn_meta, btn;
  logic [2:0]    rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    bit_idx;
  logic [5:0]    data;
  logic          rx_break;
  logic [5:0]    led;
  logic          tx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta  <= 1'b1;
      rx       <= 1'b1;
      btn_meta <= 1'b1;
      btn      <= 1'b1;
    end else begin
      rx_meta  <= pins.uart_rx;
      rx       <= rx_meta;
      btn_meta <= pins.btn;
      btn      <= btn_meta;
    end
  end

  // WAIT is one cycle short so that WAIT + READ spans exactly one bit period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      bit_idx  <= '0;
      data     <= '0;
      rx_break <= 1'b0;
      led      <= 6'b111111;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (rx) begin
            rx_break <= 1'b0;
          end else if (!rx_break) begin
            rx_cnt   <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            bit_idx  <= '0;
            rx_state <= rx ? RX_IDLE : RX_WAIT;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_WAIT: begin
          if (rx_cnt == WAIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= RX_READ;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_READ: begin
          // bits 6 and 7 are framed but never reach the LEDs
          if (bit_idx < 3'd6) data[bit_idx] <= rx;
          bit_idx  <= bit_idx + 3'd1;
          rx_state <= (bit_idx == 3'd7) ? RX_STOP : RX_WAIT;
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx) led <= ~data;
            else    rx_break <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  uart_tx_msg #(.DELAY_FRAMES(DELAY_FRAMES)) u_tx_msg (
    .clk (clk),
    .rst (rst),
    .btn (btn),
    .tx  (tx)
  );

  assign pins.uart_tx = tx;
  assign pins.led     = led;

endmodule

// File: tb/tb_uart.sv
// Scoreboard bench for uart: randomized RX bytes and button-triggered messages
// are predicted from the line protocol and checked by independent monitors.
module tb_uart;

  localparam int DF    = 8;
  localparam int BIT_T = 2 * DF;

  typedef struct {
    logic [7:0] data;
    bit         first;
  } tx_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #1 clk = ~clk;

  uart_if ifc ();

  uart #(.DELAY_FRAMES(DF)) dut (
    .clk  (clk),
    .rst  (rst),
    .pins (ifc.slave)
  );

  int         checks    = 0;
  int         failures  = 0;
  int         tx_frames = 0;
  string      msg       = "Hello UART\r\n";
  tx_exp_t    tx_q[$];
  logic [5:0] led_q[$];
  logic [5:0] led_model  = 6'h3F;
  bit         led_mon_on = 1'b0;
  bit         tx_mon_off = 1'b0;
  time        last_start = 0;

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive_bit(input logic v);
    ifc.uart_rx = v;
    repeat (DF) @(negedge clk);
  endtask

  // The model: a good stop bit shows the inverted low six bits, a bad one changes nothing
  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    logic [5:0] nxt;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (stop_ok) begin
      nxt = ~b[5:0];
      if (nxt != led_model) led_q.push_back(nxt);
      led_model = nxt;
    end
    drive_bit(stop_ok);
    ifc.uart_rx = 1'b1;
  endtask

  task automatic apply_stimulus(input logic [7:0] b, input bit stop_ok, input int gap_bits);
    send_byte(b, stop_ok);
    check_output(stop_ok ? "rx_led_valid" : "rx_led_framing", ifc.led, led_model);
    repeat (gap_bits * DF) @(negedge clk);
  endtask

  task automatic random_rx(input int n);
    logic [7:0] b;
    bit         ok;
    int         gap;
    for (int k = 0; k < n; k++) begin
      b   = 8'($urandom_range(0, 255));
      ok  = ($urandom_range(0, 3) != 0);
      gap = ok ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 3));
      apply_stimulus(b, ok, gap);
    end
  endtask

  task automatic push_message();
    tx_exp_t e;
    for (int i = 0; i < 12; i++) begin
      e.data  = msg[i];
      e.first = (i == 0);
      tx_q.push_back(e);
    end
  endtask

  // LED monitor: every visible change must match the next predicted value
  initial begin
    forever begin
      @(ifc.led);
      #1;
      if (!led_mon_on || rst) continue;
      if (led_q.size() == 0) check_output("led_unexpected_change", ifc.led, led_model);
      else                   check_output("led_update", ifc.led, led_q.pop_front());
    end
  end

  // TX monitor: decode each frame mid-bit, sampling on falling clock edges
  initial begin
    time        t0;
    logic [7:0] b;
    tx_exp_t    e;
    forever begin
      @(negedge ifc.uart_tx);
      if (tx_mon_off || rst) continue;
      t0 = $time;
      #9;
      check_output("tx_start_bit", ifc.uart_tx, 0);
      for (int i = 0; i < 8; i++) begin
        #(BIT_T);
        b[i] = ifc.uart_tx;
      end
      #(BIT_T);
      check_output("tx_stop_bit", ifc.uart_tx, 1);
      tx_frames++;
      if (tx_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL tx_extra_frame got=%0h exp=none", b);
      end else begin
        e = tx_q.pop_front();
        check_output("tx_byte", b, e.data);
        if (!e.first) check_output("tx_frame_spacing", 32'(t0 - last_start), 10 * BIT_T);
      end
      last_start = t0;
    end
  end

  initial begin
    #400000;
    failures++;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    ifc.uart_rx = 1'b1;
    ifc.btn     = 1'b1;

    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check_output("reset_led", ifc.led, 6'h3F);
      check_output("reset_tx", ifc.uart_tx, 1);
    end
    rst = 1'b0;
    led_mon_on = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] directed receive");
    apply_stimulus(8'hFF, 1'b1, 1);
    check_output("rx_ff_led", ifc.led, 6'b000000);
    apply_stimulus(8'h15, 1'b1, 1);
    check_output("rx_15_led", ifc.led, 6'b101010);
    apply_stimulus(8'h2A, 1'b1, 0);
    check_output("rx_2a_led", ifc.led, 6'b010101);
    apply_stimulus(8'h41, 1'b0, 2);
    check_output("rx_framing_led", ifc.led, 6'b010101);
    apply_stimulus(8'h00, 1'b1, 1);
    check_output("rx_00_led", ifc.led, 6'b111111);

    ifc.uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    ifc.uart_rx = 1'b1;
    repeat (3 * DF) @(negedge clk);
    check_output("glitch_led", ifc.led, led_model);
    apply_stimulus(8'h3C, 1'b1, 1);
    check_output("rx_after_glitch_led", ifc.led, 6'b000011);

    ifc.uart_rx = 1'b0;
    repeat (40 * DF) @(negedge clk);
    check_output("break_led", ifc.led, led_model);
    ifc.uart_rx = 1'b1;
    repeat (2 * DF) @(negedge clk);
    apply_stimulus(8'hC7, 1'b1, 1);

    $display("[TB] random receive");
    random_rx(15);

    $display("[TB] message with concurrent receive");
    push_message();
    ifc.btn = 1'b0;
    fork
      repeat (5000) @(negedge clk);
      random_rx(20);
    join
    ifc.btn = 1'b1;
    check_output("tx_msg1_pending", tx_q.size(), 0);
    check_output("tx_msg1_frames", tx_frames, 12);
    check_output("tx_idle_after_msg1", ifc.uart_tx, 1);

    repeat (50) @(negedge clk);
    push_message();
    ifc.btn = 1'b0;
    repeat (300) @(negedge clk);
    ifc.btn = 1'b1;
    for (int i = 0; i < 2000 && tx_q.size() != 0; i++) @(negedge clk);
    repeat (100) @(negedge clk);
    check_output("tx_msg2_pending", tx_q.size(), 0);
    check_output("tx_msg2_frames", tx_frames, 24);
    check_output("tx_idle_after_msg2", ifc.uart_tx, 1);

    for (int i = 0; i < 500 && led_q.size() != 0; i++) @(negedge clk);
    check_output("led_queue_drained", led_q.size(), 0);
    check_output("led_final", ifc.led, led_model);

    $display("[TB] reset mid-frame");
    tx_mon_off = 1'b1;
    ifc.btn = 1'b0;
    repeat (100) @(negedge clk);
    ifc.uart_rx = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("rst_mid_tx", ifc.uart_tx, 1);
    check_output("rst_mid_led", ifc.led, 6'h3F);
    ifc.btn     = 1'b1;
    ifc.uart_rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    led_model = 6'h3F;
    repeat (50) @(negedge clk);
    check_output("post_rst_tx", ifc.uart_tx, 1);
    check_output("post_rst_led", ifc.led, 6'h3F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
